// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned PS2_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    // True when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [PS2_DATA_W-1:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// Scan-code consumer interface: FIFO head, handshake, occupancy and error pulses.
interface ps2_rx_fifo_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    import ps2_pkg::*;

    localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [PS2_DATA_W-1:0] code_o;
    logic                  valid_o;
    logic                  ready_i;
    logic [COUNT_W-1:0]    count_o;
    logic                  parity_err_o;
    logic                  frame_err_o;
    logic                  overflow_o;

    modport master (
        output code_o, valid_o, count_o, parity_err_o, frame_err_o, overflow_o,
        input  ready_i
    );

    modport slave (
        input  code_o, valid_o, count_o, parity_err_o, frame_err_o, overflow_o,
        output ready_i
    );

endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter; idles high.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_o
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             filt_q, filt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output flips on the FILTER_LEN-th consecutive differing sample.
    always_comb begin
        sync1_d = line_i;
        sync2_d = sync1_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign line_o = filt_q;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered lines, framed decode with timeout, scan-code FIFO.
module ps2_rx_fifo #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 20000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           ps2_clk_i,
    input  logic           ps2_data_i,
    ps2_rx_fifo_if.master  bus
);
    import ps2_pkg::*;

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned COUNT_W = PTR_W + 1;
    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    logic clk_filt, data_filt;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .rst(rst), .line_i(ps2_clk_i), .line_o(clk_filt)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(clk), .rst(rst), .line_i(ps2_data_i), .line_o(data_filt)
    );

    ps2_state_e            state_q, state_d;
    logic                  clk_prev_q, clk_prev_d;
    logic                  strobe_q, strobe_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [PS2_DATA_W-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  push_q, push_d;
    logic [PS2_DATA_W-1:0] push_byte_q, push_byte_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  timeout_hit;

    logic [PS2_DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PS2_DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [PS2_DATA_W-1:0] code_q, code_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  pop, full, push_ok;

    assign timeout_hit = (state_q != IDLE) && !strobe_q &&
                         (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (timeout_hit) begin
            state_d = IDLE;
        end else if (strobe_q) begin
            case (state_q)
                IDLE:    if (!data_filt) state_d = DATA;
                DATA:    if (bit_idx_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame datapath and outcome pulses, evaluated on each falling-edge strobe.
    always_comb begin
        clk_prev_d  = clk_filt;
        strobe_d    = clk_prev_q && !clk_filt;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        par_d       = par_q;
        push_d      = 1'b0;
        push_byte_d = push_byte_q;
        perr_d      = 1'b0;
        ferr_d      = 1'b0;
        tmo_d       = (state_q == IDLE || strobe_q) ? '0 : tmo_q + TMO_W'(1);
        if (timeout_hit) begin
            ferr_d = 1'b1;
            tmo_d  = '0;
        end else if (strobe_q) begin
            case (state_q)
                IDLE:   bit_idx_d = '0;
                DATA: begin
                    shift_d   = {data_filt, shift_q[PS2_DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
                PARITY: par_d = data_filt;
                default: begin
                    if (!odd_parity_ok(shift_q, par_q)) begin
                        perr_d = 1'b1;
                    end else if (!data_filt) begin
                        ferr_d = 1'b1;
                    end else begin
                        push_d      = 1'b1;
                        push_byte_d = shift_q;
                    end
                end
            endcase
        end
    end

    // FIFO: a pop frees the slot a same-cycle push needs when full.
    always_comb begin
        pop      = valid_q && bus.ready_i;
        full     = (count_q == COUNT_W'(FIFO_DEPTH));
        push_ok  = push_q && (!full || pop);
        ovf_d    = push_q && full && !pop;
        mem_d    = mem_q;
        if (push_ok) mem_d[wr_ptr_q] = push_byte_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + COUNT_W'(push_ok) - COUNT_W'(pop);
        valid_d  = (count_d != '0);
        code_d   = valid_d ? mem_d[rd_ptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_prev_q  <= 1'b1;
            strobe_q    <= 1'b0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            push_q      <= 1'b0;
            push_byte_q <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            code_q      <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            clk_prev_q  <= clk_prev_d;
            strobe_q    <= strobe_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            push_q      <= push_d;
            push_byte_q <= push_byte_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            code_q      <= code_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.code_o       = code_q;
    assign bus.valid_o      = valid_q;
    assign bus.count_o      = count_q;
    assign bus.parity_err_o = perr_q;
    assign bus.frame_err_o  = ferr_q;
    assign bus.overflow_o   = ovf_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: PS/2 frame driver, queue-based reference model and pulse/code monitor.
module tb_ps2_rx_fifo;

    localparam int unsigned FL    = 4;
    localparam int unsigned TMO   = 2000;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned H     = 20;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;

    ps2_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] model_q [$];
    int         err_q   [$];   // 1 parity, 2 frame, 4 overflow

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_cyc(H);
        ps2_clk = 1'b0;
        wait_cyc(H);
        ps2_clk = 1'b1;
    endtask

    // Drives one frame and records what the consumer should see for it.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit measure, input bit pop_sync);
        logic par;
        int   lat;
        int   n_high;
        par = (~^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_data = !bad_stop;
        wait_cyc(H);
        if (bad_par)                                                        err_q.push_back(1);
        else if (bad_stop)                                                  err_q.push_back(2);
        else if (!pop_sync && !bus.ready_i && model_q.size() >= int'(DEPTH)) err_q.push_back(4);
        else                                                                model_q.push_back(b);
        ps2_clk = 1'b0;
        if (pop_sync) begin
            repeat (FL + 4) @(posedge clk);
            @(negedge clk);
            bus.ready_i = 1'b1;
            @(negedge clk);
            bus.ready_i = 1'b0;
            wait_cyc(H - FL - 5);
        end else if (measure) begin
            lat    = -1;
            n_high = 0;
            for (int k = 1; k <= int'(H); k++) begin
                @(negedge clk);
                #1;
                if (bus.valid_o) begin
                    if (lat < 0) lat = k - 1;
                    n_high++;
                end
            end
            check("valid_latency", 32'(lat), 32'(FL + 4));
            check("valid_width", 32'(n_high), 32'd1);
        end else begin
            wait_cyc(H);
        end
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(H);
    endtask

    task automatic send_partial(input int n_bits);
        ps2_bit(1'b0);
        for (int i = 0; i < n_bits; i++) ps2_bit(1'($urandom_range(0, 1)));
    endtask

    // Monitor: consumes every handshake and every error pulse against the expectation queues.
    initial begin
        logic [2:0] got;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus.valid_o && bus.ready_i) begin
                    if (model_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_code: got 0x%0h required none", bus.code_o);
                    end else begin
                        check("code", 32'(bus.code_o), 32'(model_q.pop_front()));
                    end
                end
                got = {bus.overflow_o, bus.frame_err_o, bus.parity_err_o};
                if (got != 3'b000) begin
                    if (err_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pulse: got %b required none", got);
                    end else begin
                        check("err_pulse", 32'(got), 32'(err_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int kind;
        bus.ready_i = 1'b1;
        wait_cyc(5);
        #1;
        check("rst_code",  32'(bus.code_o),  32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_count", 32'(bus.count_o), 32'd0);
        check("rst_pulses", 32'({bus.parity_err_o, bus.frame_err_o, bus.overflow_o}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(10);

        send_frame(8'h1C, 1'b0, 1'b0, 1'b1, 1'b0);

        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        check("perr_valid", 32'(bus.valid_o), 32'd0);
        check("perr_count", 32'(bus.count_o), 32'd0);

        ps2_clk = 1'b0;
        wait_cyc(FL - 1);
        ps2_clk = 1'b1;
        wait_cyc(20);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

        bus.ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("full_count", 32'(bus.count_o), 32'(DEPTH));
        check("full_head", 32'(bus.code_o), 32'h01);

        send_frame(8'h06, 1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        check("pushpop_count", 32'(bus.count_o), 32'(DEPTH));
        check("pushpop_head", 32'(bus.code_o), 32'h02);
        @(negedge clk);
        bus.ready_i = 1'b1;
        wait_cyc(10);
        #1;
        check("drain_count", 32'(bus.count_o), 32'd0);
        check("drain_model", 32'(model_q.size()), 32'd0);

        send_partial(3);
        err_q.push_back(2);
        wait_cyc(TMO + 100);
        check("timeout_seen", 32'(err_q.size()), 32'd0);
        send_frame(8'h76, 1'b0, 1'b0, 1'b0, 1'b0);

        send_partial(4);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        check("midrst_count", 32'(bus.count_o), 32'd0);
        check("midrst_code",  32'(bus.code_o),  32'd0);
        model_q.delete();
        wait_cyc(20);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            bus.ready_i = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            send_frame(8'($urandom_range(0, 255)), kind == 0 || kind == 2, kind == 1 || kind == 2,
                       1'b0, 1'b0);
        end

        bus.ready_i = 1'b1;
        for (int k = 0; k < 100 && (model_q.size() != 0 || err_q.size() != 0); k++) wait_cyc(1);
        wait_cyc(5);
        check("end_model_empty", 32'(model_q.size()), 32'd0);
        check("end_err_empty",   32'(err_q.size()),   32'd0);
        #1;
        check("end_count", 32'(bus.count_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
